morse_char_assembler: RTL and testbench

Sequencing stage downstream of the dit/dah classifier. It accepts the classifier's per-element symbol stream (DIT, DAH, GAP, SPACE) and accumulates DIT/DAH elements into a character pattern. On a character gap or word space it closes the pattern, and it emits finished character and word-space tokens through a small ready/valid FIFO to the character decoder. It owns the pattern register, the element counter, word tracking and output buffering; it performs no timing classification itself.

---
 rtl/morse_char_assembler.sv | 168 ++++++++++++++++
 tb/tb_morse_char_assembler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_assembler.sv
// Collects DIT/DAH elements into character patterns and queues finished
// character (and, with MORSE_SPACE_TOKEN_EN defined, word-space) tokens in a small output FIFO.
module morse_char_assembler #(
    parameter int MAX_SYMS   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       bigclk,
    input  logic       reset,
    input  logic       sym_valid,
    input  logic [2:0] sym,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_bits,
    output logic [2:0] out_len,
    output logic       out_space,
    output logic       out_err,
    output logic       overrun,
    output logic [2:0] fill
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;

    localparam logic [2:0] SYM_DIT   = 3'd1;
    localparam logic [2:0] SYM_DAH   = 3'd2;
    localparam logic [2:0] SYM_GAP   = 3'd3;
    localparam logic [2:0] SYM_SPACE = 3'd4;

    localparam logic [10:0] SPACE_TOK = {1'b1, 10'd0};

`ifdef MORSE_SPACE_TOKEN_EN
    localparam logic SPACE_EN = 1'b1;
`else
    localparam logic SPACE_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } col_state_t;

    logic [5:0]  pat_q, pat_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;
    logic [PW-1:0] wr_q, rd_q;
    logic [10:0] mem_q [FIFO_DEPTH];

    col_state_t  state;
    logic        char_push;
    logic [10:0] char_tok;
    logic        push_v;
    logic [10:0] push_tok;
    logic [PW-1:0] count;
    logic        full;
    logic        pop;
    logic        do_push;
    logic [10:0] head_tok;

    // The element counter doubles as the IDLE/COLLECT state register.
    assign state    = (cnt_q == 3'd0) ? ST_IDLE : ST_COLLECT;
    assign char_tok = {1'b0, err_q, cnt_q, pat_q};

    always_comb begin
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        char_push = 1'b0;
        if (sym_valid) begin
            case (sym)
                SYM_DIT, SYM_DAH: begin
                    if (cnt_q < 3'(MAX_SYMS)) begin
                        pat_d = pat_q | ({5'd0, sym == SYM_DAH} << cnt_q);
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                SYM_GAP, SYM_SPACE: begin
                    if (state == ST_COLLECT) begin
                        char_push = 1'b1;
                        pat_d     = 6'd0;
                        cnt_d     = 3'd0;
                        err_d     = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MORSE_SPACE_TOKEN_EN
    logic word_open_q, word_open_d;
    logic space_pend_q, space_pend_d;
    logic space_now;

    // A SPACE landing while a space is already pending is absorbed by it.
    always_comb begin
        space_now    = sym_valid && (sym == SYM_SPACE) && (state == ST_IDLE)
                       && word_open_q && !space_pend_q;
        space_pend_d = char_push && (sym == SYM_SPACE);
        word_open_d  = word_open_q;
        if (char_push) begin
            word_open_d = 1'b1;
        end else if (space_pend_q || space_now) begin
            word_open_d = 1'b0;
        end
        push_v   = char_push || space_pend_q || space_now;
        push_tok = char_push ? char_tok : SPACE_TOK;
    end

    always_ff @(posedge bigclk or posedge reset) begin
        if (reset) begin
            word_open_q  <= 1'b0;
            space_pend_q <= 1'b0;
        end else begin
            word_open_q  <= word_open_d;
            space_pend_q <= space_pend_d;
        end
    end
`else
    always_comb begin
        push_v   = char_push;
        push_tok = char_tok;
    end
`endif

    always_comb begin
        count     = wr_q - rd_q;
        full      = (count == PW'(FIFO_DEPTH));
        out_valid = (count != '0);
        pop       = out_valid && out_ready;
        do_push   = push_v && (!full || pop);
        overrun_d = overrun_q || (push_v && full && !pop);
        head_tok  = out_valid ? mem_q[rd_q[AW-1:0]] : 11'd0;
    end

    always_ff @(posedge bigclk or posedge reset) begin
        if (reset) begin
            pat_q     <= 6'd0;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            if (do_push) wr_q <= wr_q + PW'(1);
            if (pop)     rd_q <= rd_q + PW'(1);
        end
    end

    // Token storage carries no reset; stale entries are masked by the pointers.
    always_ff @(posedge bigclk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_tok;
    end

    assign out_space = head_tok[10] & SPACE_EN;
    assign out_err   = head_tok[9];
    assign out_len   = head_tok[8:6];
    assign out_bits  = head_tok[5:0];
    assign overrun   = overrun_q;
    assign fill      = 3'(count);

endmodule

// File: tb/tb_morse_char_assembler.sv
// Directed self-checking bench for morse_char_assembler; head token compared as
// {valid, space, err, len[2:0], bits[5:0]}.
module tb_morse_char_assembler;

    logic       bigclk;
    logic       reset;
    logic       sym_valid;
    logic [2:0] sym;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_bits;
    logic [2:0] out_len;
    logic       out_space;
    logic       out_err;
    logic       overrun;
    logic [2:0] fill;
    logic [11:0] head;

    int checks   = 0;
    int failures = 0;

`ifdef MORSE_SPACE_TOKEN_EN
    localparam bit SP_EN = 1'b1;
`else
    localparam bit SP_EN = 1'b0;
`endif

    morse_char_assembler #(.MAX_SYMS(6), .FIFO_DEPTH(4)) dut (
        .bigclk    (bigclk),
        .reset     (reset),
        .sym_valid (sym_valid),
        .sym       (sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_len   (out_len),
        .out_space (out_space),
        .out_err   (out_err),
        .overrun   (overrun),
        .fill      (fill)
    );

    assign head = {out_valid, out_space, out_err, out_len, out_bits};

    initial bigclk = 1'b0;
    always #5 bigclk = ~bigclk;

    task automatic tick();
        @(posedge bigclk);
        #1;
    endtask

    task automatic send(input logic [2:0] s);
        sym_valid = 1'b1;
        sym       = s;
        tick();
        sym_valid = 1'b0;
        sym       = 3'd0;
    endtask

    task automatic drain_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (head !== 12'h000) begin
            failures++;
            $display("FAIL reset_head got=%h exp=%h", head, 12'h000);
        end
        checks++;
        if ({overrun, fill} !== 4'h0) begin
            failures++;
            $display("FAIL reset_ovr_fill got=%h exp=%h", {overrun, fill}, 4'h0);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (head !== 12'h000) begin
            failures++;
            $display("FAIL post_reset_head got=%h exp=%h", head, 12'h000);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        send(3'd1); send(3'd2); send(3'd3);
        checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 3'd2, 6'b000010}) begin
            failures++;
            $display("FAIL basic_head got=%h exp=%h", head, {1'b1, 1'b0, 1'b0, 3'd2, 6'b000010});
        end
        checks++;
        if (fill !== 3'd1) begin
            failures++;
            $display("FAIL basic_fill got=%0d exp=1", fill);
        end
        drain_one();
        checks++;
        if ({head, fill} !== 15'h0) begin
            failures++;
            $display("FAIL basic_drained got=%h exp=0", {head, fill});
        end
        $display("test_basic done");
    endtask

    task automatic test_too_long();
        for (int i = 0; i < 7; i++) send(3'd1);
        send(3'd3);
        checks++;
        if (head !== {1'b1, 1'b0, 1'b1, 3'd6, 6'b000000}) begin
            failures++;
            $display("FAIL long_head got=%h exp=%h", head, {1'b1, 1'b0, 1'b1, 3'd6, 6'b000000});
        end
        send(3'd2); send(3'd3);
        drain_one();
        checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001}) begin
            failures++;
            $display("FAIL long_next_clean got=%h exp=%h", head, {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001});
        end
        drain_one();
        checks++;
        if (fill !== 3'd0) begin
            failures++;
            $display("FAIL long_drain_fill got=%0d exp=0", fill);
        end
        $display("test_too_long done");
    endtask

    task automatic test_space();
        logic [2:0] exp_fill;
        exp_fill = SP_EN ? 3'd2 : 3'd1;
        send(3'd2); send(3'd4);
        checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001}) begin
            failures++;
            $display("FAIL space_char got=%h exp=%h", head, {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001});
        end
        send(3'd4);
        checks++;
        if (fill !== exp_fill) begin
            failures++;
            $display("FAIL space_fill_2nd got=%0d exp=%0d", fill, exp_fill);
        end
        send(3'd4);
        checks++;
        if (fill !== exp_fill) begin
            failures++;
            $display("FAIL space_fill_3rd got=%0d exp=%0d", fill, exp_fill);
        end
        drain_one();
        checks++;
        if (head !== (SP_EN ? {1'b1, 1'b1, 1'b0, 3'd0, 6'd0} : 12'h000)) begin
            failures++;
            $display("FAIL space_token got=%h exp=%h", head,
                     (SP_EN ? {1'b1, 1'b1, 1'b0, 3'd0, 6'd0} : 12'h000));
        end
        drain_one();
        checks++;
        if (fill !== 3'd0) begin
            failures++;
            $display("FAIL space_drain_fill got=%0d exp=0", fill);
        end
        $display("test_space done");
    endtask

    task automatic test_fifo_full();
        logic [11:0] exp_tok [4];
        exp_tok[0] = {1'b1, 1'b0, 1'b0, 3'd1, 6'b000000};
        exp_tok[1] = {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001};
        exp_tok[2] = {1'b1, 1'b0, 1'b0, 3'd2, 6'b000010};
        exp_tok[3] = {1'b1, 1'b0, 1'b0, 3'd2, 6'b000011};
        out_ready = 1'b0;
        send(3'd1); send(3'd3);
        send(3'd2); send(3'd3);
        send(3'd1); send(3'd2); send(3'd3);
        send(3'd2); send(3'd2); send(3'd3);
        send(3'd1); send(3'd1); send(3'd3);
        checks++;
        if ({overrun, fill} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL full_ovr_fill got=%h exp=%h", {overrun, fill}, {1'b1, 3'd4});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (head !== exp_tok[i]) begin
                failures++;
                $display("FAIL full_order[%0d] got=%h exp=%h", i, head, exp_tok[i]);
            end
            drain_one();
        end
        checks++;
        if ({overrun, fill} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL full_sticky got=%h exp=%h", {overrun, fill}, {1'b1, 3'd0});
        end
        pulse_reset();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL full_ovr_cleared got=%b exp=0", overrun);
        end
        $display("test_fifo_full done");
    endtask

    task automatic test_full_pop();
        logic [11:0] exp_tok [4];
        exp_tok[0] = {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001};
        exp_tok[1] = {1'b1, 1'b0, 1'b0, 3'd2, 6'b000001};
        exp_tok[2] = {1'b1, 1'b0, 1'b0, 3'd2, 6'b000000};
        exp_tok[3] = {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001};
        out_ready = 1'b0;
        send(3'd1); send(3'd3);
        send(3'd2); send(3'd3);
        send(3'd2); send(3'd1); send(3'd3);
        send(3'd1); send(3'd1); send(3'd3);
        send(3'd2);
        sym_valid = 1'b1;
        sym       = 3'd3;
        out_ready = 1'b1;
        tick();
        sym_valid = 1'b0;
        sym       = 3'd0;
        out_ready = 1'b0;
        checks++;
        if ({overrun, fill} !== {1'b0, 3'd4}) begin
            failures++;
            $display("FAIL fullpop_ovr_fill got=%h exp=%h", {overrun, fill}, {1'b0, 3'd4});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (head !== exp_tok[i]) begin
                failures++;
                $display("FAIL fullpop_order[%0d] got=%h exp=%h", i, head, exp_tok[i]);
            end
            drain_one();
        end
        $display("test_full_pop done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(3'd2); send(3'd3);
        end
        send(3'd1); send(3'd2);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({head, overrun, fill} !== 16'h0) begin
            failures++;
            $display("FAIL midreset_async got=%h exp=0", {head, overrun, fill});
        end
        tick();
        reset = 1'b0;
        send(3'd1); send(3'd3);
        checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 3'd1, 6'b000000}) begin
            failures++;
            $display("FAIL midreset_next got=%h exp=%h", head, {1'b1, 1'b0, 1'b0, 3'd1, 6'b000000});
        end
        checks++;
        if (fill !== 3'd1) begin
            failures++;
            $display("FAIL midreset_fill got=%0d exp=1", fill);
        end
        drain_one();
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(3'd1); send(3'd3);
        checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 3'd1, 6'b000000}) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", head, {1'b1, 1'b0, 1'b0, 3'd1, 6'b000000});
        end
        send(3'd2);
        checks++;
        if (fill !== 3'd0) begin
            failures++;
            $display("FAIL b2b_popped got=%0d exp=0", fill);
        end
        send(3'd3);
        checks++;
        if (head !== {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001}) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", head, {1'b1, 1'b0, 1'b0, 3'd1, 6'b000001});
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (fill !== 3'd0) begin
            failures++;
            $display("FAIL b2b_end_fill got=%0d exp=0", fill);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym       = 3'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_too_long();
        test_space();
        test_fifo_full();
        test_full_pop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
